switch_line_rx: RTL
===================

Name: switch_line_rx

Overview:
- Receive end of the single-wire serial line that our switch-level CMOS drivers produce.
- The input stage restores the line level with two cascaded CMOS inverters built from nmos/pmos primitives on supply0/supply1 nets.
- It then synchronizes the line, detects the start bit, samples each bit at mid-period, checks parity and stop, and presents the deserialized word.
- Sits between the pad-level switch network and the register-level logic.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- BIT_CYC, 8, clock cycles per bit period (even, ≥4).
- PARITY_EN, 1, 1 = even parity bit present between data and stop; 0 = no parity bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- line  input  1  serial line; idle high.
- rx_data  output  DATA_W  last received word, LSB first on the wire.
- rx_valid  output  1  one-cycle pulse when a frame completes without a stop error.
- parity_err  output  1  parity mismatch flag, valid with rx_valid.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Input stage: line passes through two CMOS inverters (nmos/pmos switch primitives, gnd/vdd supply nets), giving a non-inverted restored signal. That signal feeds a 2-flop synchronizer; s_line is the second flop output.
- Synchronizer reset value is 1, so no false start is seen after reset. All timing below is relative to s_line, which lags line by 2 cycles.
- Reset, synchronous: state=IDLE, counters=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
- rst overrides everything, including mid-frame. A partial frame is discarded with no flags.
- Counters: cyc_cnt (clog2(BIT_CYC) bits) and bit_idx (clog2(DATA_W+1) bits).
- State machine:
  - IDLE: when s_line==0 and previous s_line==1 (falling edge), go to START with cyc_cnt=0.
  - START: count to BIT_CYC/2-1 (mid-bit), then check s_line.
    - If s_line==1: glitch; return to IDLE with no flags.
    - Otherwise: go to DATA with cyc_cnt=0 and bit_idx=0.
  - DATA: when cyc_cnt==BIT_CYC-1, shift s_line into the shift register MSB-first-shift (so wire LSB ends in bit 0), clear cyc_cnt, increment bit_idx.
    - After DATA_W samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: after BIT_CYC cycles, sample the parity bit. Compute perr = XOR(shift register) XOR sample, i.e. even parity over data+parity. Go to STOP.
  - STOP: after BIT_CYC cycles, sample the stop bit.
    - If it is 1: load rx_data from the shift register, pulse rx_valid for 1 cycle, and put perr on parity_err. parity_err holds until the next rx_valid or reset.
    - If it is 0: pulse frame_err; rx_valid stays 0 and rx_data is unchanged.
    - Either way, return to IDLE on the next cycle.
- A new falling edge is recognized only in IDLE. A start edge arriving during STOP's final cycle is missed; senders must idle ≥1 bit between frames.
- Line held low continuously: after a frame_err, IDLE needs a 1→0 edge to restart. No lockup, no repeated errors.
- PARITY_EN=0: parity_err stays 0 permanently.
- busy is registered and rises the cycle after START is entered.
- Latency: rx_valid is asserted 2 + BIT_CYC/2 + (DATA_W + PARITY_EN + 1)·BIT_CYC cycles (±1) after the line falling edge. The bench must accept a ±1 window.

Test Plan:
- Defaults; send 0xA5 (parity bit 0, stop 1) → rx_valid pulse once, rx_data=0xA5, parity_err=0, frame_err=0, busy low after the frame.
- Send 0x3C with parity bit forced 1 → rx_valid=1, rx_data=0x3C, parity_err=1. A following correct 0x01 (parity 1) clears parity_err to 0.
- Send 0x55 with stop bit 0 → frame_err single-cycle pulse, rx_valid never asserts, rx_data keeps its prior value. Hold line low 50 cycles → no further pulses.
- Low glitch of 2 cycles on the idle line → state returns to IDLE, no rx_valid, no frame_err; busy high for at most BIT_CYC/2+1 cycles.
- Assert rst mid-DATA of a 0xFF frame, release, then send 0x81 → only 0x81 is reported, rx_valid once, no errors.
- PARITY_EN=0, DATA_W=5, BIT_CYC=4; back-to-back frames 0x1F, 0x00 with 1-bit idle gap → two rx_valid pulses, data 0x1F then 0x00, parity_err constant 0.

Source files
------------

// File: rtl/switch_line_rx.sv
// switch_line_rx: CMOS-restored serial line receiver (clk, rst, line -> rx_data, rx_valid, parity_err, frame_err, busy)
module switch_line_rx #(
  parameter int DATA_W    = 8,
  parameter int BIT_CYC   = 8,
  parameter bit PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(BIT_CYC);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  supply0 gnd;
  supply1 vdd;
  wire inv_line, restored;
  pmos p_a (inv_line, vdd, line);
  nmos n_a (inv_line, gnd, line);
  pmos p_b (restored, vdd, inv_line);
  nmos n_b (restored, gnd, inv_line);
  logic [2:0] state;
  logic s_meta, s_line, s_prev, perr, half, full;
  logic [CW-1:0] cyc_cnt;
  logic [IW-1:0] bit_idx;
  logic [DATA_W-1:0] shreg;
  always_comb begin
    half = cyc_cnt == CW'(BIT_CYC / 2 - 1);
    full = cyc_cnt == CW'(BIT_CYC - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s_meta, s_line, s_prev} <= 3'b111;
      state <= IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      perr <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      s_meta <= restored;
      s_line <= s_meta;
      s_prev <= s_line;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= state != IDLE;
      cyc_cnt <= (full || state == IDLE) ? '0 : cyc_cnt + 1'b1;
      case (state)
        IDLE: if (s_prev && !s_line) state <= START;
        START: if (half) begin
          cyc_cnt <= '0;
          bit_idx <= '0;
          state <= s_line ? IDLE : DATA;
        end
        DATA: if (full) begin
          shreg <= DATA_W'({s_line, shreg} >> 1);
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == IW'(DATA_W - 1)) state <= PARITY_EN ? PARITY : STOP;
        end
        PARITY: if (full) begin
          perr <= ^shreg ^ s_line;
          state <= STOP;
        end
        STOP: if (full) begin
          if (s_line) begin
            rx_data <= shreg;
            rx_valid <= 1'b1;
            parity_err <= perr;
          end else frame_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
